// File: rtl/ysyx_23060136_exu_div.sv
// Multi-cycle 32-bit divider for DIV/DIVU/REM/REMU: restoring radix-2, one quotient bit per cycle.
// Divide-by-zero and signed overflow complete in a single cycle.
`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif

module ysyx_23060136_exu_div (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               DIV_valid_i,
  output logic                               DIV_ready_o,
  input  logic [1:0]                         DIV_op,
  input  logic [`ysyx_23060136_BITS_W-1:0]   DIV_da,
  input  logic [`ysyx_23060136_BITS_W-1:0]   DIV_db,
  input  logic                               DIV_flush,
  output logic                               DIV_valid_o,
  input  logic                               DIV_ready_i,
  output logic [`ysyx_23060136_BITS_W-1:0]   DIV_result
);

  localparam int W = `ysyx_23060136_BITS_W;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_reg;
  logic [5:0]     cnt_reg;
  logic [1:0]     op_reg;
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   quo_reg;
  logic [W-1:0]   dvs_reg;
  logic           q_neg_reg;
  logic           r_neg_reg;

  // Operand preparation at accept time; op[0]==0 selects the signed variants.
  logic           is_signed;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           overflow;

  assign is_signed = ~DIV_op[0];
  assign a_neg     = is_signed & DIV_da[W-1];
  assign b_neg     = is_signed & DIV_db[W-1];
  assign abs_a     = a_neg ? (~DIV_da + 1'b1) : DIV_da;
  assign abs_b     = b_neg ? (~DIV_db + 1'b1) : DIV_db;
  assign overflow  = is_signed && (DIV_da == {1'b1, {(W-1){1'b0}}}) && (DIV_db == {W{1'b1}});

  // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic           fits;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   quo_step;

  assign shifted  = {rem_reg, quo_reg[W-1]};
  assign diff     = shifted - {1'b0, dvs_reg};
  assign fits     = ~diff[W];
  assign rem_step = fits ? diff[W-1:0] : shifted[W-1:0];
  assign quo_step = {quo_reg[W-2:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
    end else if (DIV_flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (DIV_valid_i) begin
            op_reg    <= DIV_op;
            cnt_reg   <= '0;
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
            dvs_reg   <= abs_b;
            if (DIV_db == '0) begin
              quo_reg   <= {W{1'b1}};
              rem_reg   <= DIV_da;
              state_reg <= DONE;
            end else if (overflow) begin
              quo_reg   <= {1'b1, {(W-1){1'b0}}};
              rem_reg   <= '0;
              state_reg <= DONE;
            end else begin
              quo_reg   <= abs_a;
              rem_reg   <= '0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            quo_reg   <= q_neg_reg ? (~quo_step + 1'b1) : quo_step;
            rem_reg   <= r_neg_reg ? (~rem_step + 1'b1) : rem_step;
            state_reg <= DONE;
          end else begin
            quo_reg <= quo_step;
            rem_reg <= rem_step;
          end
        end
        DONE: begin
          if (DIV_ready_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DIV_ready_o = (state_reg == IDLE);
  assign DIV_valid_o = (state_reg == DONE);
  assign DIV_result  = op_reg[1] ? rem_reg : quo_reg;

endmodule

// File: tb/tb_ysyx_23060136_exu_div.sv
// Directed self-checking bench for ysyx_23060136_exu_div: results, latency, stall, flush, reset.
`timescale 1ns/1ps

module tb_ysyx_23060136_exu_div;

  logic        clk;
  logic        rst;
  logic        DIV_valid_i;
  logic        DIV_ready_o;
  logic [1:0]  DIV_op;
  logic [31:0] DIV_da;
  logic [31:0] DIV_db;
  logic        DIV_flush;
  logic        DIV_valid_o;
  logic        DIV_ready_i;
  logic [31:0] DIV_result;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  ysyx_23060136_exu_div dut (
    .clk         (clk),
    .rst         (rst),
    .DIV_valid_i (DIV_valid_i),
    .DIV_ready_o (DIV_ready_o),
    .DIV_op      (DIV_op),
    .DIV_da      (DIV_da),
    .DIV_db      (DIV_db),
    .DIV_flush   (DIV_flush),
    .DIV_valid_o (DIV_valid_o),
    .DIV_ready_i (DIV_ready_i),
    .DIV_result  (DIV_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present a request for one edge, then scramble inputs to prove they were latched.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    DIV_valid_i = 1'b1;
    DIV_op      = op;
    DIV_da      = a;
    DIV_db      = b;
    @(posedge clk);
    #1;
    DIV_valid_i = 1'b0;
    DIV_op      = 2'($urandom);
    DIV_da      = $urandom;
    DIV_db      = $urandom;
  endtask

  // Returns the edge index (accept = edge 0) at which DIV_valid_o is first seen; 0 on timeout.
  task automatic wait_valid(output int lat);
    int k;
    lat = 0;
    k   = 0;
    while (lat == 0 && k < 45) begin
      @(negedge clk);
      k++;
      if (DIV_valid_o) lat = k;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check(tag, DIV_result, exp);
    DIV_ready_i = 1'b1;
    @(posedge clk);
    #1;
    DIV_ready_i = 1'b0;
    check({tag, "_idle"}, {30'd0, DIV_ready_o, DIV_valid_o}, 32'h2);
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", op, a, b, exp, lat);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (DIV_valid_o) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int lat;
    rst         = 1'b1;
    DIV_valid_i = 1'b0;
    DIV_op      = 2'b00;
    DIV_da      = '0;
    DIV_db      = '0;
    DIV_flush   = 1'b0;
    DIV_ready_i = 1'b0;
    #12;
    check("reset_ready",  {31'd0, DIV_ready_o}, 32'd1);
    check("reset_valid",  {31'd0, DIV_valid_o}, 32'd0);
    check("reset_result", DIV_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal path results
    run_op("div_100_7",   OP_DIV,  32'd100,       32'd7, 32'd14,        33);
    run_op("rem_100_7",   OP_REM,  32'd100,       32'd7, 32'd2,         33);
    run_op("rem_m7_2",    OP_REM,  32'hFFFFFFF9,  32'd2, 32'hFFFFFFFF,  33);
    run_op("div_m7_2",    OP_DIV,  32'hFFFFFFF9,  32'd2, 32'hFFFFFFFD,  33);
    run_op("divu_max_2",  OP_DIVU, 32'hFFFFFFFF,  32'd2, 32'h7FFFFFFF,  33);
    run_op("div_7_m2",    OP_DIV,  32'd7,   32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_op("remu_1000_7", OP_REMU, 32'd1000,      32'd7, 32'd6,         33);

    // Single-cycle special cases
    run_op("divu_5_0",    OP_DIVU, 32'd5,         32'd0, 32'hFFFFFFFF,  1);
    run_op("remu_5_0",    OP_REMU, 32'd5,         32'd0, 32'd5,         1);
    run_op("rem_m7_0",    OP_REM,  32'hFFFFFFF9,  32'd0, 32'hFFFFFFF9,  1);
    run_op("div_ovf",     OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",     OP_REM,  32'h80000000,  32'hFFFFFFFF, 32'd0,  1);
    run_op("divu_nonovf", OP_DIVU, 32'h80000000,  32'hFFFFFFFF, 32'd0,  33);

    // Downstream stall: result must hold while DIV_ready_i is low
    start_op(OP_DIV, 32'd100, 32'd7);
    wait_valid(lat);
    check("stall_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid",  {31'd0, DIV_valid_o}, 32'd1);
      check("stall_result", DIV_result, 32'd14);
    end
    DIV_ready_i = 1'b1;
    @(posedge clk);
    #1;
    DIV_ready_i = 1'b0;
    check("stall_release", {30'd0, DIV_ready_o, DIV_valid_o}, 32'h2);
    $display("stall: result held 10 cycles then released");

    // Flush at counter 10 kills the operation
    start_op(OP_DIVU, 32'd12345, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("calc_busy", {31'd0, DIV_ready_o}, 32'd0);
    DIV_flush = 1'b1;
    @(posedge clk);
    #1;
    DIV_flush = 1'b0;
    check("flush_idle", {30'd0, DIV_ready_o, DIV_valid_o}, 32'h2);
    watch_no_valid("flush_no_valid", 40);
    $display("flush: operation abandoned at counter 10");
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33);

    // Flush blocks a same-cycle accept
    @(negedge clk);
    DIV_valid_i = 1'b1;
    DIV_flush   = 1'b1;
    DIV_op      = OP_DIVU;
    DIV_da      = 32'd5;
    DIV_db      = 32'd0;
    @(posedge clk);
    #1;
    DIV_valid_i = 1'b0;
    DIV_flush   = 1'b0;
    check("flush_block", {30'd0, DIV_ready_o, DIV_valid_o}, 32'h2);
    watch_no_valid("flush_block_nv", 3);
    $display("flush: same-cycle accept blocked");

    // Flush together with ready in DONE returns to IDLE
    start_op(OP_DIVU, 32'd5, 32'd0);
    @(negedge clk);
    check("done_valid", {31'd0, DIV_valid_o}, 32'd1);
    DIV_flush   = 1'b1;
    DIV_ready_i = 1'b1;
    @(posedge clk);
    #1;
    DIV_flush   = 1'b0;
    DIV_ready_i = 1'b0;
    check("flush_ready_idle", {30'd0, DIV_ready_o, DIV_valid_o}, 32'h2);
    $display("flush+ready in DONE: back to IDLE");

    // Asynchronous reset mid-CALC
    start_op(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready",  {31'd0, DIV_ready_o}, 32'd1);
    check("arst_valid",  {31'd0, DIV_valid_o}, 32'd0);
    check("arst_result", DIV_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_valid("arst_no_valid", 40);
    check("arst_result_after", DIV_result, 32'd0);
    $display("async reset mid-CALC: operation abandoned");
    run_op("after_reset", OP_REM, 32'd100, 32'd7, 32'd2, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_exu_div.md
YSYX_23060136_EXU_DIV -- requirements
Module: ysyx_23060136_EXU_DIV

Interface
REQ-001 SHALL use clock and reset as decided: one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-002 SHALL size every data port at `ysyx_23060136_BITS_W (32).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 DIV_valid_i  input  1  operand request from EXU1.
REQ-006 DIV_ready_o  output  1  unit can accept a request.
REQ-007 DIV_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 DIV_da  input  32  dividend, taken from EXU1_ALU_da.
REQ-009 DIV_db  input  32  divisor, taken from EXU1_ALU_db.
REQ-010 DIV_flush  input  1  kill in-flight operation (branch/trap redirect).
REQ-011 DIV_valid_o  output  1  result available.
REQ-012 DIV_ready_i  input  1  downstream (EXU2 segment) accepts the result.
REQ-013 DIV_result  output  32  quotient or remainder as selected by the captured op.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE; DIV_ready_o = (state==IDLE); DIV_valid_o = (state==DONE).
REQ-015 Accept SHALL occur on an edge where DIV_valid_i & DIV_ready_o & !DIV_flush; on accept, op, dividend and divisor SHALL be latched, and later input changes SHALL be ignored.
REQ-016 Signed ops SHALL divide absolute values and record sign flags; unsigned ops SHALL use raw operands.
REQ-017 On accept with divisor==0, SHALL go IDLE->DONE: quotient 0xFFFFFFFF, remainder = raw dividend, for both signed and unsigned ops.
REQ-018 On accept of a signed op with dividend 0x80000000 and divisor 0xFFFFFFFF, SHALL go IDLE->DONE: quotient 0x80000000, remainder 0.
REQ-019 Otherwise SHALL go IDLE->CALC with a 6-bit counter = 0 and perform a restoring radix-2 step per cycle: shift {rem,quo} left 1; if rem >= divisor, subtract and set the quotient LSB.
REQ-020 CALC SHALL last exactly 32 cycles; on the edge where counter==31, SHALL apply sign correction and go to DONE.
REQ-021 Sign correction SHALL negate the quotient when the operand signs differ (signed ops only) and give the remainder the dividend's sign.
REQ-022 Latency: accept at edge 0 -> DIV_valid_o high from edge 33 (normal path) or edge 1 (special cases in REQ-017/018).
REQ-023 In DONE, DIV_result SHALL hold stable until DIV_valid_o & DIV_ready_i; the FSM then SHALL return to IDLE on that edge.
REQ-024 Back-to-back operation: no accept SHALL occur in the DONE cycle; the next accept is possible no earlier than the following cycle.
REQ-025 DIV_flush SHALL force IDLE on the next edge from any state, discard the result, and block a same-cycle accept.
REQ-026 DIV_flush and DIV_ready_i together in DONE SHALL both return to IDLE; the handshake SHALL count as completed.
REQ-027 Counter SHALL not wrap; it is cleared on every accept.

Reset
REQ-028 rst SHALL immediately force state IDLE, counter 0 and all datapath registers 0.
REQ-029 During reset: DIV_ready_o=1, DIV_valid_o=0, DIV_result=0.
REQ-030 Reset asserted mid-CALC or in DONE SHALL abandon the operation; no DIV_valid_o pulse SHALL follow.

Verification
REQ-031 DIV 100/7 accepted at edge 0 -> DIV_valid_o rises at edge 33, DIV_result=14; REM same operands -> 2.
REQ-032 REM -7/2 -> 0xFFFFFFFF (-1); DIV -7/2 -> 0xFFFFFFFD (-3); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF at edge 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at edge 1, REM -> 0.
REQ-034 DIV_ready_i held low 10 cycles in DONE -> DIV_valid_o and DIV_result stable throughout; DIV_ready_i=1 -> IDLE next edge.
REQ-035 DIV_flush at CALC counter 10 -> IDLE next edge, DIV_ready_o=1, no DIV_valid_o; a new request is then accepted and gives the correct result.
REQ-036 rst pulsed asynchronously mid-CALC (between edges) -> outputs immediately at reset values; no stale result after release.
